// File: rtl/nfc_pkg.sv
// Shared constants, state encodings and address helper
// for the NAND flash copy controller.
package nfc_pkg;

    localparam int PAGE_BYTES_DEF = 512;
    localparam int PAGE_NUM_DEF   = 512;
    localparam int TWB_CYC_DEF    = 5;

    localparam logic [7:0] CMD_READ0 = 8'h00;
    localparam logic [7:0] CMD_PROG  = 8'h80;
    localparam logic [7:0] CMD_PCONF = 8'h10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_CMD,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_PG_CMD,
        ST_PG_ADDR,
        ST_XFER_RD,
        ST_XFER_WR,
        ST_PG_CONF,
        ST_PG_WAIT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_CMD,
        OP_ADDR,
        OP_WDATA,
        OP_RDATA
    } op_e;

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_WLO,
        BUS_WHI,
        BUS_RLO1,
        BUS_RLO2,
        BUS_RHI
    } bus_e;

    // Address cycle idx: column, row low, row high.
    function automatic logic [7:0] addr_byte(
        input logic [8:0] page,
        input logic [1:0] idx
    );
        case (idx)
            2'd1:    return page[7:0];
            2'd2:    return {7'b0, page[8]};
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/nfc_bus_seq.sv
// One flash bus cycle at a time: strobe timing,
// IO tristate enable and read-data capture.
module nfc_bus_seq
    import nfc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  op_e        kind,
    input  logic [7:0] data_in,
    input  logic [7:0] io_in,
    output logic       busy,
    output logic       ack,
    output logic       cle,
    output logic       ale,
    output logic       wen,
    output logic       ren,
    output logic       io_oe,
    output logic [7:0] io_out,
    output logic [7:0] rd_data
);

    bus_e       st;
    bus_e       st_d;
    op_e        kind_q;
    logic [7:0] data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st      <= BUS_IDLE;
            kind_q  <= OP_CMD;
            data_q  <= 8'h00;
            rd_data <= 8'h00;
        end else begin
            st <= st_d;
            if (st == BUS_IDLE && start) begin
                kind_q <= kind;
                data_q <= data_in;
            end
            // Sampled on the edge that returns REN high.
            if (st == BUS_RLO2) begin
                rd_data <= io_in;
            end
        end
    end

    always_comb begin
        st_d   = st;
        busy   = (st != BUS_IDLE);
        ack    = 1'b0;
        cle    = 1'b0;
        ale    = 1'b0;
        wen    = 1'b1;
        ren    = 1'b1;
        io_oe  = 1'b0;
        io_out = data_q;
        unique case (st)
            BUS_IDLE: begin
                if (start) begin
                    st_d = (kind == OP_RDATA) ? BUS_RLO1 : BUS_WLO;
                end
            end
            BUS_WLO: begin
                wen   = 1'b0;
                io_oe = 1'b1;
                cle   = (kind_q == OP_CMD);
                ale   = (kind_q == OP_ADDR);
                st_d  = BUS_WHI;
            end
            BUS_WHI: begin
                io_oe = 1'b1;
                cle   = (kind_q == OP_CMD);
                ale   = (kind_q == OP_ADDR);
                ack   = 1'b1;
                st_d  = BUS_IDLE;
            end
            BUS_RLO1: begin
                ren  = 1'b0;
                st_d = BUS_RLO2;
            end
            BUS_RLO2: begin
                ren  = 1'b0;
                st_d = BUS_RHI;
            end
            BUS_RHI: begin
                ack  = 1'b1;
                st_d = BUS_IDLE;
            end
            default: st_d = BUS_IDLE;
        endcase
    end

endmodule

// File: rtl/nfc_copy_ctrl.sv
// Page-by-page copy of flash A into flash B:
// read page, program same page, wait ready, repeat.
module nfc_copy_ctrl
    import nfc_pkg::*;
#(
    parameter int PAGE_BYTES = PAGE_BYTES_DEF,
    parameter int PAGE_NUM   = PAGE_NUM_DEF,
    parameter int TWB_CYC    = TWB_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic       done,
    inout  wire  [7:0] F_IO_A,
    output logic       F_CLE_A,
    output logic       F_ALE_A,
    output logic       F_REN_A,
    output logic       F_WEN_A,
    input  logic       F_RB_A,
    inout  wire  [7:0] F_IO_B,
    output logic       F_CLE_B,
    output logic       F_ALE_B,
    output logic       F_REN_B,
    output logic       F_WEN_B,
    input  logic       F_RB_B
);

    localparam logic [8:0] LAST_BYTE = 9'(PAGE_BYTES - 1);
    localparam logic [8:0] LAST_PAGE = 9'(PAGE_NUM - 1);
    localparam logic [3:0] TWB       = 4'(TWB_CYC);

    state_e     state;
    state_e     state_d;
    logic [8:0] page;
    logic [8:0] bcnt;
    logic [1:0] aidx;
    logic [3:0] wcnt;
    logic [7:0] data_q;
    logic       wait_ok;

    logic       a_start, a_busy, a_ack, a_oe;
    op_e        a_kind;
    logic [7:0] a_data, a_out, a_rd;
    logic       b_start, b_busy, b_ack, b_oe;
    op_e        b_kind;
    logic [7:0] b_data, b_out, b_rd_unused;

    assign F_IO_A  = a_oe ? a_out : 8'bz;
    assign F_IO_B  = b_oe ? b_out : 8'bz;
    assign wait_ok = (wcnt == TWB);
    assign done    = (state == ST_DONE);

    nfc_bus_seq u_seq_a (
        .clk     (clk),
        .rst     (rst),
        .start   (a_start),
        .kind    (a_kind),
        .data_in (a_data),
        .io_in   (F_IO_A),
        .busy    (a_busy),
        .ack     (a_ack),
        .cle     (F_CLE_A),
        .ale     (F_ALE_A),
        .wen     (F_WEN_A),
        .ren     (F_REN_A),
        .io_oe   (a_oe),
        .io_out  (a_out),
        .rd_data (a_rd)
    );

    nfc_bus_seq u_seq_b (
        .clk     (clk),
        .rst     (rst),
        .start   (b_start),
        .kind    (b_kind),
        .data_in (b_data),
        .io_in   (F_IO_B),
        .busy    (b_busy),
        .ack     (b_ack),
        .cle     (F_CLE_B),
        .ale     (F_ALE_B),
        .wen     (F_WEN_B),
        .ren     (F_REN_B),
        .io_oe   (b_oe),
        .io_out  (b_out),
        .rd_data (b_rd_unused)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            page   <= 9'd0;
            bcnt   <= 9'd0;
            aidx   <= 2'd0;
            wcnt   <= 4'd0;
            data_q <= 8'h00;
        end else begin
            state <= state_d;
            if ((state == ST_RD_ADDR && a_ack) ||
                (state == ST_PG_ADDR && b_ack)) begin
                aidx <= (aidx == 2'd2) ? 2'd0 : aidx + 2'd1;
            end
            if (state == ST_XFER_RD && a_ack) begin
                data_q <= a_rd;
            end
            if (state == ST_XFER_WR && b_ack) begin
                bcnt <= (bcnt == LAST_BYTE) ? 9'd0 : bcnt + 9'd1;
            end
            if (state == ST_PG_WAIT && state_d == ST_RD_CMD) begin
                page <= page + 9'd1;
            end
            // tWB guard counts only inside the two wait states.
            if (state == ST_RD_WAIT || state == ST_PG_WAIT) begin
                if (!wait_ok) begin
                    wcnt <= wcnt + 4'd1;
                end
            end else begin
                wcnt <= 4'd0;
            end
        end
    end

    always_comb begin
        state_d = state;
        a_start = 1'b0;
        a_kind  = OP_CMD;
        a_data  = CMD_READ0;
        b_start = 1'b0;
        b_kind  = OP_CMD;
        b_data  = CMD_PROG;
        unique case (state)
            ST_IDLE: state_d = ST_RD_CMD;
            ST_RD_CMD: begin
                a_start = !a_busy;
                if (a_ack) state_d = ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                a_start = !a_busy;
                a_kind  = OP_ADDR;
                a_data  = addr_byte(page, aidx);
                if (a_ack && aidx == 2'd2) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wait_ok && F_RB_A) state_d = ST_PG_CMD;
            end
            ST_PG_CMD: begin
                b_start = !b_busy;
                if (b_ack) state_d = ST_PG_ADDR;
            end
            ST_PG_ADDR: begin
                b_start = !b_busy;
                b_kind  = OP_ADDR;
                b_data  = addr_byte(page, aidx);
                if (b_ack && aidx == 2'd2) state_d = ST_XFER_RD;
            end
            ST_XFER_RD: begin
                a_start = !a_busy;
                a_kind  = OP_RDATA;
                if (a_ack) state_d = ST_XFER_WR;
            end
            ST_XFER_WR: begin
                b_start = !b_busy;
                b_kind  = OP_WDATA;
                b_data  = data_q;
                if (b_ack) begin
                    state_d = (bcnt == LAST_BYTE) ? ST_PG_CONF : ST_XFER_RD;
                end
            end
            ST_PG_CONF: begin
                b_start = !b_busy;
                b_data  = CMD_PCONF;
                if (b_ack) state_d = ST_PG_WAIT;
            end
            ST_PG_WAIT: begin
                if (wait_ok && F_RB_B) begin
                    state_d = (page == LAST_PAGE) ? ST_DONE : ST_RD_CMD;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nfc_copy_ctrl.sv
// Copy controller bench: behavioural flash A/B models,
// random page data, abort-and-restart and long-busy cases.
module tb_nfc_copy_ctrl;

    localparam int PB  = 2;
    localparam int PN  = 512;
    localparam int TWB = 5;
    localparam int SZ  = PB * PN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    wire  [7:0] io_a;
    wire  [7:0] io_b;
    logic       done;
    logic       cle_a, ale_a, ren_a, wen_a;
    logic       cle_b, ale_b, ren_b, wen_b;
    logic       rb_a = 1'b1;
    logic       rb_b = 1'b1;
    logic [7:0] a_q;

    assign io_a = !ren_a ? a_q : 8'bz;

    nfc_copy_ctrl #(
        .PAGE_BYTES (PB),
        .PAGE_NUM   (PN),
        .TWB_CYC    (TWB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .done    (done),
        .F_IO_A  (io_a),
        .F_CLE_A (cle_a),
        .F_ALE_A (ale_a),
        .F_REN_A (ren_a),
        .F_WEN_A (wen_a),
        .F_RB_A  (rb_a),
        .F_IO_B  (io_b),
        .F_CLE_B (cle_b),
        .F_ALE_B (ale_b),
        .F_REN_B (ren_b),
        .F_WEN_B (wen_b),
        .F_RB_B  (rb_b)
    );

    logic [7:0] mem_a [SZ];
    logic [7:0] mem_b [SZ];
    logic [7:0] buf_b [PB];
    logic [9:0] a_log [$];
    logic [9:0] b_log [$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int a_cmd, a_acnt, a_row, a_ptr, a_busy;
    int b_cmd, b_acnt, b_row, b_ptr, b_busy;
    int b_col;
    int p257_col = -1, p257_lo = -1, p257_hi = -1;
    int busy_strobes = 0, viol = 0, done_rises = 0;
    int prog_cnt = 0, last_prog = -1;
    int long_cyc = 0, long_gap = -1;
    bit long_pend = 0, long_used = 0;
    bit run2 = 0, p3_xfer = 0, done_prev = 0, ren_prev = 1;

    assign a_q = mem_a[(a_row * PB + a_ptr) % SZ];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flash A: latch cmd/addr on WEN rise, stream page on REN rises.
    always @(posedge clk) begin
        cyc++;
        if (!wen_a) begin
            a_log.push_back({cle_a, ale_a, io_a});
            if (cle_a) begin
                a_cmd  = int'(io_a);
                a_acnt = 0;
            end else if (ale_a) begin
                if (a_acnt == 1) a_row = int'(io_a);
                if (a_acnt == 2) a_row = a_row + int'(io_a) * 256;
                a_acnt++;
                if (a_acnt == 3 && a_cmd == 0) begin
                    a_ptr  = 0;
                    a_busy = int'($urandom_range(3, 12));
                end
            end
        end
        if (ren_a && !ren_prev) a_ptr++;
        ren_prev = ren_a;
    end

    // Flash B: page buffer, program on 0x10, track busy behaviour.
    always @(posedge clk) begin
        if ((cle_a && ale_a) || (cle_b && ale_b) ||
            (!ren_a && !wen_a) || (!ren_b && !wen_b)) viol++;
        if (done && !done_prev) done_rises++;
        done_prev = done;
        if (!wen_b) begin
            if (!rb_b) busy_strobes++;
            if (long_pend) begin
                long_gap  = cyc - long_cyc;
                long_pend = 0;
            end
            b_log.push_back({cle_b, ale_b, io_b});
            if (cle_b) begin
                b_cmd  = int'(io_b);
                b_acnt = 0;
                if (b_cmd == 8'h80) begin
                    b_ptr = 0;
                    for (int i = 0; i < PB; i++) buf_b[i] = 8'hFF;
                end else if (b_cmd == 8'h10) begin
                    for (int i = 0; i < PB; i++)
                        mem_b[(b_row * PB + i) % SZ] &= buf_b[i];
                    last_prog = b_row;
                    prog_cnt++;
                    if (run2 && b_row == 1 && !long_used) begin
                        b_busy    = 500;
                        long_used = 1;
                        long_pend = 1;
                        long_cyc  = cyc;
                    end else begin
                        b_busy = int'($urandom_range(3, 12));
                    end
                end
            end else if (ale_b) begin
                if (b_acnt == 0) b_col = int'(io_b);
                if (b_acnt == 1) b_row = int'(io_b);
                if (b_acnt == 2) begin
                    b_row = b_row + int'(io_b) * 256;
                    if (b_row == 257) begin
                        p257_col = b_col;
                        p257_lo  = b_row % 256;
                        p257_hi  = int'(io_b);
                    end
                end
                b_acnt++;
            end else begin
                if (b_ptr < PB) buf_b[b_ptr] = io_b;
                b_ptr++;
                if (!run2 && b_row == 3) p3_xfer = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (a_busy > 0) begin
            rb_a = 1'b0;
            a_busy--;
        end else begin
            rb_a = 1'b1;
        end
        if (b_busy > 0) begin
            rb_b = 1'b0;
            b_busy--;
        end else begin
            rb_b = 1'b1;
        end
    end

    function automatic logic [7:0] strobes();
        return {ren_a, wen_a, ren_b, wen_b, cle_a, ale_a, cle_b, ale_b};
    endfunction

    initial begin
        int bad;
        for (int i = 0; i < SZ; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'hFF;
        end
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_strobes", 32'(strobes()), 32'h0F0);
        chk("reset_done", 32'(done), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 5000 && !p3_xfer; i++) @(negedge clk);
        chk("reach_p3_xfer", 32'(p3_xfer), 32'h1);
        rst = 1'b0;
        #1;
        chk("abort_strobes", 32'(strobes()), 32'h0F0);
        chk("abort_done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        a_log.delete();
        b_log.delete();
        done_rises = 0;
        prog_cnt   = 0;
        run2       = 1;
        rst        = 1'b1;

        for (int i = 0; i < 60000 && !done; i++) @(negedge clk);
        chk("done_timeout", 32'(done), 32'h1);
        repeat (5) @(negedge clk);

        chk("a_cmd0", 32'(a_log[0]), 32'h200);
        chk("a_addr0", 32'(a_log[1]), 32'h100);
        chk("a_addr1", 32'(a_log[2]), 32'h100);
        chk("a_addr2", 32'(a_log[3]), 32'h100);
        chk("b_cmd0", 32'(b_log[0]), 32'h280);
        chk("b_addr0", 32'(b_log[1]), 32'h100);
        chk("b_addr1", 32'(b_log[2]), 32'h100);
        chk("b_addr2", 32'(b_log[3]), 32'h100);
        chk("p257_col", 32'(p257_col), 32'd0);
        chk("p257_lo", 32'(p257_lo), 32'(257 % 256));
        chk("p257_hi", 32'(p257_hi), 32'(257 / 256));
        chk("busy_strobes", 32'(busy_strobes), 32'd0);
        chk("long_busy_gap", 32'(long_gap >= 500), 32'h1);
        chk("done_rises", 32'(done_rises), 32'd1);
        chk("done_held", 32'(done), 32'h1);
        chk("done_strobes", 32'(strobes()), 32'h0F0);
        chk("prog_count", 32'(prog_cnt), 32'(PN));
        chk("last_prog", 32'(last_prog), 32'(PN - 1));
        chk("protocol", 32'(viol), 32'd0);
        bad = 0;
        for (int i = 0; i < SZ; i++) begin
            if (mem_b[i] !== mem_a[i]) bad++;
        end
        chk("copy_bytes_bad", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
